// File: rtl/fetch_queue_pkg.sv
// Shared constants and entry layout for the fetch-to-decode instruction queue.
package fetch_queue_pkg;

  localparam int FQ_WIDTH = 32;
  localparam int FQ_DEPTH = 4;
  localparam logic [FQ_WIDTH-1:0] FQ_NOP = 32'h0000_0000;  // sll $0,$0,0

  typedef struct packed {
    logic [FQ_WIDTH-1:0] instr;
    logic [FQ_WIDTH-1:0] pc;
  } fq_entry_t;

  // Pointer advance; wraps naturally because DEPTH is a power of two.
  function automatic logic [$clog2(FQ_DEPTH)-1:0] fq_next_ptr(
    input logic [$clog2(FQ_DEPTH)-1:0] ptr
  );
    return ptr + {{($clog2(FQ_DEPTH)-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/fq_storage.sv
// Entry array for the fetch queue: one synchronous write port, one
// asynchronous read port, cleared by reset.
module fq_storage #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [PTR_W-1:0]   waddr,
  input  logic [2*WIDTH-1:0] wdata,
  input  logic [PTR_W-1:0]   raddr,
  output logic [2*WIDTH-1:0] rdata
);

  logic [2*WIDTH-1:0] mem_r [DEPTH];

  // Write port with asynchronous clear of every entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (we) begin
      mem_r[waddr] <= wdata;
    end else begin
      mem_r[waddr] <= mem_r[waddr];
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Show-ahead instruction queue between fetch and decode: back-pressures the
// PC when full and drops all contents on a control-flow flush.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int WIDTH = FQ_WIDTH,
  parameter int DEPTH = FQ_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] instr_fetch,
  input  logic [WIDTH-1:0] pc_fetch,
  input  logic             fetch_valid,
  input  logic             flush_decode,
  input  logic             decode_ready,
  output logic [WIDTH-1:0] instr_decode,
  output logic [WIDTH-1:0] pc_decode,
  output logic             decode_valid,
  output logic             stall_pc,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] ONE_CNT  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] ONE_PTR = PTR_W'(1);

  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [PTR_W:0]     count_r;
  logic               push_s;
  logic               pop_s;
  logic [2*WIDTH-1:0] wdata_s;
  logic [2*WIDTH-1:0] rdata_s;

  // Status depends on count alone, so no path from decode_ready to stall_pc.
  assign decode_valid = (count_r != {(PTR_W+1){1'b0}});
  assign stall_pc     = (count_r == FULL_CNT);
  assign count        = count_r;

  assign push_s  = fetch_valid & ~stall_pc & ~flush_decode;
  assign pop_s   = decode_valid & decode_ready & ~flush_decode;
  assign wdata_s = {instr_fetch, pc_fetch};

  fq_storage #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_storage (
    .clk   (clk),
    .rst   (rst),
    .we    (push_s),
    .waddr (wr_ptr_r),
    .wdata (wdata_s),
    .raddr (rd_ptr_r),
    .rdata (rdata_s)
  );

  // Pointer and occupancy update; flush beats push and pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (flush_decode) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      wr_ptr_r <= push_s ? wr_ptr_r + ONE_PTR : wr_ptr_r;
      rd_ptr_r <= pop_s ? rd_ptr_r + ONE_PTR : rd_ptr_r;
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + ONE_CNT;
        2'b01:   count_r <= count_r - ONE_CNT;
        default: count_r <= count_r;
      endcase
    end
  end

  // Head presentation; an empty queue shows NOP with a zero pc.
  always_comb begin
    instr_decode = FQ_NOP;
    pc_decode    = {WIDTH{1'b0}};
    if (decode_valid) begin
      instr_decode = rdata_s[2*WIDTH-1:WIDTH];
      pc_decode    = rdata_s[WIDTH-1:0];
    end else begin
      instr_decode = FQ_NOP;
      pc_decode    = {WIDTH{1'b0}};
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (DEPTH=4, WIDTH=32).
module tb_fetch_queue;

  logic        clk;
  logic        rst;
  logic [31:0] instr_fetch;
  logic [31:0] pc_fetch;
  logic        fetch_valid;
  logic        flush_decode;
  logic        decode_ready;
  logic [31:0] instr_decode;
  logic [31:0] pc_decode;
  logic        decode_valid;
  logic        stall_pc;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  fetch_queue dut (
    .clk          (clk),
    .rst          (rst),
    .instr_fetch  (instr_fetch),
    .pc_fetch     (pc_fetch),
    .fetch_valid  (fetch_valid),
    .flush_decode (flush_decode),
    .decode_ready (decode_ready),
    .instr_decode (instr_decode),
    .pc_decode    (pc_decode),
    .decode_valid (decode_valid),
    .stall_pc     (stall_pc),
    .count        (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_status(input string tag, input logic [2:0] exp_cnt);
    chk({tag, "_count"}, 32'(count), 32'(exp_cnt));
    chk({tag, "_valid"}, 32'(decode_valid), 32'(exp_cnt != 3'd0));
    chk({tag, "_stall"}, 32'(stall_pc), 32'(exp_cnt == 3'd4));
  endtask

  task automatic chk_head(input string tag, input logic [31:0] ei, input logic [31:0] ep);
    chk({tag, "_instr"}, instr_decode, ei);
    chk({tag, "_pc"}, pc_decode, ep);
  endtask

  // Pointer distance must agree with occupancy modulo DEPTH.
  task automatic chk_inv(input string tag);
    logic [1:0] d;
    d = dut.wr_ptr_r - dut.rd_ptr_r;
    chk({tag, "_inv"}, 32'(d), 32'(count[1:0]));
  endtask

  initial begin
    rst = 1'b1;
    instr_fetch = 32'h0;
    pc_fetch = 32'h0;
    fetch_valid = 1'b0;
    flush_decode = 1'b0;
    decode_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_status("reset", 3'd0);
    chk_head("reset", 32'h0, 32'h0);
    step();
    chk_status("idle", 3'd0);
    chk_head("idle", 32'h0, 32'h0);

    // Fill with decode holding.
    for (int i = 1; i <= 4; i++) begin
      fetch_valid = 1'b1;
      instr_fetch = 32'h2008_0000 + 32'(i);
      pc_fetch = 32'(4 * i);
      step();
      chk_status("fill", 3'(i));
      chk_head("fill", 32'h2008_0001, 32'd4);
      chk_inv("fill");
    end
    instr_fetch = 32'h2008_0005;
    pc_fetch = 32'd20;
    step();
    chk_status("full_drop", 3'd4);
    chk_head("full_drop", 32'h2008_0001, 32'd4);

    // Drain; first pop occurs while full, so the concurrent push is blocked.
    decode_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk_head("drain", 32'h2008_0000 + 32'(i), 32'(4 * i));
      step();
      fetch_valid = 1'b0;
      chk_status("drain", 3'(4 - i));
      chk_inv("drain");
    end
    chk_head("drained", 32'h0, 32'h0);
    step();
    chk_status("empty_ready", 3'd0);
    decode_ready = 1'b0;

    // Stream with one prefilled entry; pointers wrap several times.
    fetch_valid = 1'b1;
    instr_fetch = 32'h3000_0000;
    pc_fetch = 32'h100;
    step();
    chk_status("prefill", 3'd1);
    decode_ready = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      chk_head("stream", 32'h3000_0000 + 32'(k - 1), 32'h100 + 32'(4 * (k - 1)));
      instr_fetch = 32'h3000_0000 + 32'(k);
      pc_fetch = 32'h100 + 32'(4 * k);
      step();
      chk_status("stream", 3'd1);
      chk_inv("stream");
    end
    decode_ready = 1'b0;
    fetch_valid = 1'b0;
    chk_head("stream_end", 32'h3000_000A, 32'h128);
    chk("stream_wr", 32'(dut.wr_ptr_r), 32'd3);

    // Flush at count 3 with push and pop requested in the same cycle.
    fetch_valid = 1'b1;
    instr_fetch = 32'h4000_0001;
    step();
    instr_fetch = 32'h4000_0002;
    step();
    chk_status("pre_flush", 3'd3);
    instr_fetch = 32'h4000_0003;
    decode_ready = 1'b1;
    flush_decode = 1'b1;
    step();
    flush_decode = 1'b0;
    decode_ready = 1'b0;
    chk_status("flush", 3'd0);
    chk_head("flush", 32'h0, 32'h0);
    chk_inv("flush");
    instr_fetch = 32'h5000_0001;
    pc_fetch = 32'h200;
    #1;
    chk("no_bypass", 32'(decode_valid), 32'd0);
    step();
    chk_status("post_flush", 3'd1);
    chk_head("post_flush", 32'h5000_0001, 32'h200);

    // Flush while full: stall drops the cycle after.
    repeat (3) step();
    fetch_valid = 1'b0;
    chk_status("refill", 3'd4);
    flush_decode = 1'b1;
    step();
    flush_decode = 1'b0;
    chk_status("flush_full", 3'd0);

    // Asynchronous reset between edges with two entries queued.
    fetch_valid = 1'b1;
    instr_fetch = 32'h6000_0001;
    pc_fetch = 32'h300;
    step();
    instr_fetch = 32'h6000_0002;
    step();
    fetch_valid = 1'b0;
    chk_status("pre_rst", 3'd2);
    #1;
    rst = 1'b1;
    #1;
    chk_status("async_rst", 3'd0);
    chk_head("async_rst", 32'h0, 32'h0);
    #1;
    rst = 1'b0;
    fetch_valid = 1'b1;
    instr_fetch = 32'h7000_0001;
    pc_fetch = 32'h400;
    step();
    fetch_valid = 1'b0;
    chk_status("resume", 3'd1);
    chk_head("resume", 32'h7000_0001, 32'h400);
    chk_inv("resume");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction buffer between the fetch stage and the decode stage.
- Holds up to DEPTH {instruction, pc+4} pairs produced by fetch.
- Presents the oldest pair to decode through a valid/ready handshake.
- Back-pressures the PC with stall_pc when full, and discards all contents on a control-flow flush, so decode stalls are decoupled from fetch.

Parameters:
- WIDTH, 32, data/address width; equals `WIDTH from defines.v.
- DEPTH, 4, number of entries; must be a power of two, 2..16.
- PTR_W, $clog2(DEPTH), pointer width.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- instr_fetch  input  WIDTH  instruction from fetch
- pc_fetch  input  WIDTH  pc+4 from fetch
- fetch_valid  input  1  push request; fetch has a valid pair this cycle
- flush_decode  input  1  taken branch/jump; discard all entries
- decode_ready  input  1  decode accepts the head entry this cycle
- instr_decode  output  WIDTH  head instruction; `NOP when empty
- pc_decode  output  WIDTH  head pc+4; 0 when empty
- decode_valid  output  1  head entry valid (queue not empty)
- stall_pc  output  1  queue full; fetch must hold PC
- count  output  PTR_W+1  occupancy, 0..DEPTH

Behaviour:
- Reset: async on rst=1.
  - wr_ptr, rd_ptr and count go to 0; storage is cleared to 0.
  - Outputs during and after reset: decode_valid=0, stall_pc=0, instr_decode=`NOP (32'h0), pc_decode=0, count=0.
  - Reset mid-operation drops all entries immediately, with no partial pop.
- Qualified events per cycle:
  - push = fetch_valid & ~stall_pc & ~flush_decode
  - pop = decode_valid & decode_ready & ~flush_decode
- push: writes {instr_fetch, pc_fetch} at wr_ptr on the clock edge. wr_ptr increments modulo DEPTH (natural wrap of PTR_W bits).
- pop: rd_ptr increments modulo DEPTH.
- count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Show-ahead output:
  - The head entry is driven combinationally from the registered storage at rd_ptr.
  - Write-to-read latency is 1 cycle: data pushed at edge N is visible at decode_valid after edge N.
  - There is no same-cycle bypass from fetch to decode.
- Full (count==DEPTH):
  - stall_pc=1 and push is blocked, even if pop occurs the same cycle.
  - stall_pc depends only on count, so there is no combinational path from decode_ready.
  - Entries are never overwritten.
- Empty (count==0): decode_valid=0 and outputs show the NOP/0 values. decode_ready is ignored.
- Simultaneous push and pop (0<count<DEPTH): both occur and count is unchanged.
- Flush:
  - On the next edge, wr_ptr=rd_ptr=0 and count=0.
  - Any push or pop in the flush cycle is discarded.
  - Storage contents need not be cleared.
  - Flush together with full: stall_pc drops the cycle after.
- Flush has priority over push and pop. rst has priority over everything.
- Invariant: count equals wr_ptr-rd_ptr (mod DEPTH), disambiguated by full versus empty. The bench asserts this.
- Decode's hold semantics are expressed solely through decode_ready=0; the head entry and its outputs stay stable while decode_valid=1 and decode_ready=0.

Decomposition:
- Shared (defines.v):
  - `WIDTH
  - `NOP (32'h0000_0000, sll $0,$0,0)
  - FQ_DEPTH default
- Sub-module fq_storage:
  - DEPTH x 2*WIDTH register array.
  - One synchronous write port (we, waddr, wdata) and one asynchronous read port (raddr, rdata).
  - Async reset clears the array.
- The top level holds the pointers, count, the flush/priority logic and output muxing.

Test Plan:
- Reset then idle: rst pulse, fetch_valid=0 → decode_valid=0, instr_decode=0, pc_decode=0, stall_pc=0, count=0.
- Fill: push instrs 0x20080001..0x20080004 (pc 4,8,12,16) with decode_ready=0 → count=4 and stall_pc=1 after the 4th edge; a 5th push (0x20080005) is dropped; head is 0x20080001/pc 4.
- Drain in order: from full, decode_ready=1 for 4 cycles → outputs 0x20080001, 02, 03, 04 in order; then decode_valid=0, count=0, stall_pc=0 after the first pop edge.
- Wrap and concurrent push/pop: 10 cycles of streaming with fetch_valid=1 and decode_ready=1 after one prefill → count holds at 1; pointers wrap past 3→0; output order matches input order, with no loss or duplication.
- Flush: count=3, flush_decode=1 with fetch_valid=1 and decode_ready=1 in the same cycle → next cycle count=0 and decode_valid=0; the first push after the flush appears as the head one cycle later.
- Async reset mid-stream: assert rst between edges with count=2 → outputs go to reset values immediately without waiting for clk; normal pushing resumes after rst deasserts.
